// File: rtl/seg7_pkg.sv
// Shared constants, reset values and FSM encoding for the two-digit
// seven-segment scan controller.
package seg7_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_DIGIT0 = 2'd0;
    localparam logic [1:0] ADDR_DIGIT1 = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_RAW = 1;
    localparam int CTRL_INV = 2;

    // Register reset values
    localparam logic [7:0] RST_DIGIT  = 8'h00;
    localparam logic [2:0] RST_CTRL   = 3'b001;
    localparam logic [7:0] RST_PERIOD = 8'h0F;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOW0 = 3'd1,
        ST_GAP0  = 3'd2,
        ST_SHOW1 = 3'd3,
        ST_GAP1  = 3'd4
    } state_e;

    // Pin pattern for a dark display, honouring output inversion
    function automatic logic [6:0] blank_pattern(input logic inv);
        return inv ? 7'h7F : 7'h00;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register access bus between the I2C target (master) and the scan
// controller (slave).
interface seg7_scan_ctrl_if;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern (segment a on bit 0).
module seg7_hex_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Lookup of the segment pattern for each hex glyph
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0:    o_seg = 7'h3F;
            4'h1:    o_seg = 7'h06;
            4'h2:    o_seg = 7'h5B;
            4'h3:    o_seg = 7'h4F;
            4'h4:    o_seg = 7'h66;
            4'h5:    o_seg = 7'h6D;
            4'h6:    o_seg = 7'h7D;
            4'h7:    o_seg = 7'h07;
            4'h8:    o_seg = 7'h7F;
            4'h9:    o_seg = 7'h6F;
            4'hA:    o_seg = 7'h77;
            4'hB:    o_seg = 7'h7C;
            4'hC:    o_seg = 7'h39;
            4'hD:    o_seg = 7'h5E;
            4'hE:    o_seg = 7'h79;
            4'hF:    o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed seven-segment scan controller. A register file is
// written/read over the bus; each frame snapshots the registers into shadows
// and scans SHOW0 -> GAP0 -> SHOW1 -> GAP1 with blanking gaps in between.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int PRESCALE_W  = 8,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_ctrl_if.slave        bus,
    output logic [6:0]             seg_pins_o,
    output logic                   seg_select_o,
    output logic                   frame_o
);

    localparam logic [7:0]            GAP_LAST  = 8'(DEAD_CYCLES - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_MAX = {PRESCALE_W{1'b1}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    // Live registers
    logic [7:0] r_digit0;
    logic [7:0] r_digit1;
    logic [2:0] r_ctrl;
    logic [7:0] r_period;

    // Per-frame shadows (digit bit 7 and EN are never displayed)
    logic [6:0] r_sh_digit0;
    logic [6:0] r_sh_digit1;
    logic       r_sh_raw;
    logic       r_sh_inv;
    logic [7:0] r_sh_period;

    state_e                r_state;
    state_e                w_next_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_next;

    logic       w_enter_show0;
    logic       w_enter_show1;
    logic       w_show;
    logic [6:0] w_sh_digit0;
    logic [6:0] w_sh_digit1;
    logic       w_sh_raw;
    logic       w_sh_inv;
    logic [6:0] w_digit;
    logic [6:0] w_hex;
    logic [6:0] w_seg_val;
    logic [6:0] w_pins_next;
    logic [7:0] w_rd_mux;

    // Register file writes; the new value is visible from the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit0 <= RST_DIGIT;
            r_digit1 <= RST_DIGIT;
            r_ctrl   <= RST_CTRL;
            r_period <= RST_PERIOD;
        end else if (bus.wr_valid) begin
            case (bus.wr_addr)
                ADDR_DIGIT0: r_digit0 <= bus.wr_data;
                ADDR_DIGIT1: r_digit1 <= bus.wr_data;
                ADDR_CTRL:   r_ctrl   <= bus.wr_data[2:0];
                ADDR_PERIOD: r_period <= bus.wr_data;
                default:     r_digit0 <= r_digit0;
            endcase
        end
    end

    // Read mux over the live registers
    always_comb begin
        w_rd_mux = 8'h00;
        case (bus.rd_addr)
            ADDR_DIGIT0: w_rd_mux = r_digit0;
            ADDR_DIGIT1: w_rd_mux = r_digit1;
            ADDR_CTRL:   w_rd_mux = {5'b00000, r_ctrl};
            ADDR_PERIOD: w_rd_mux = r_period;
            default:     w_rd_mux = 8'h00;
        endcase
    end

    // Read response one cycle after the request; sampling before the write
    // lands makes a colliding read return the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 8'h00;
        end else begin
            bus.rd_valid <= bus.rd_req;
            bus.rd_data  <= bus.rd_req ? w_rd_mux : 8'h00;
        end
    end

    // Next state and counters: prescaler ticks count PERIOD+1 scan steps
    // per SHOW, r_cnt doubles as the gap cycle counter
    always_comb begin
        w_next_state = r_state;
        w_presc_next = r_presc;
        w_cnt_next   = r_cnt;
        if (!r_ctrl[CTRL_EN]) begin
            w_next_state = ST_IDLE;
            w_presc_next = '0;
            w_cnt_next   = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_SHOW0;
                    w_presc_next = '0;
                    w_cnt_next   = 8'd0;
                end
                ST_SHOW0, ST_SHOW1: begin
                    w_presc_next = r_presc + PRESC_ONE;
                    if (r_presc == PRESC_MAX) begin
                        if (r_cnt == r_sh_period) begin
                            w_next_state = (r_state == ST_SHOW0) ? ST_GAP0 : ST_GAP1;
                            w_cnt_next   = 8'd0;
                        end else begin
                            w_cnt_next = r_cnt + 8'd1;
                        end
                    end else begin
                        w_cnt_next = r_cnt;
                    end
                end
                ST_GAP0, ST_GAP1: begin
                    w_presc_next = '0;
                    if (r_cnt == GAP_LAST) begin
                        w_next_state = (r_state == ST_GAP0) ? ST_SHOW1 : ST_SHOW0;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_presc_next = '0;
                    w_cnt_next   = 8'd0;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_presc <= w_presc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Shadow values seen by the display in the coming cycle; on a SHOW0
    // entry these are the pre-write live values being captured
    always_comb begin
        w_enter_show0 = (w_next_state == ST_SHOW0) && (r_state != ST_SHOW0);
        w_enter_show1 = (w_next_state == ST_SHOW1) && (r_state != ST_SHOW1);
        w_show        = (w_next_state == ST_SHOW0) || (w_next_state == ST_SHOW1);
        if (w_enter_show0) begin
            w_sh_digit0 = r_digit0[6:0];
            w_sh_digit1 = r_digit1[6:0];
            w_sh_raw    = r_ctrl[CTRL_RAW];
            w_sh_inv    = r_ctrl[CTRL_INV];
        end else begin
            w_sh_digit0 = r_sh_digit0;
            w_sh_digit1 = r_sh_digit1;
            w_sh_raw    = r_sh_raw;
            w_sh_inv    = r_sh_inv;
        end
    end

    // Shadow capture on each frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_digit0 <= RST_DIGIT[6:0];
            r_sh_digit1 <= RST_DIGIT[6:0];
            r_sh_raw    <= RST_CTRL[CTRL_RAW];
            r_sh_inv    <= RST_CTRL[CTRL_INV];
            r_sh_period <= RST_PERIOD;
        end else if (w_enter_show0) begin
            r_sh_digit0 <= r_digit0[6:0];
            r_sh_digit1 <= r_digit1[6:0];
            r_sh_raw    <= r_ctrl[CTRL_RAW];
            r_sh_inv    <= r_ctrl[CTRL_INV];
            r_sh_period <= r_period;
        end
    end

    seg7_hex_decode u_hex (
        .i_nibble (w_digit[3:0]),
        .o_seg    (w_hex)
    );

    // Segment pattern for the state being entered
    always_comb begin
        w_digit   = (w_next_state == ST_SHOW1) ? w_sh_digit1 : w_sh_digit0;
        w_seg_val = w_sh_raw ? w_digit : w_hex;
        if (w_show) begin
            w_pins_next = w_seg_val ^ {7{w_sh_inv}};
        end else begin
            w_pins_next = blank_pattern(r_ctrl[CTRL_INV]);
        end
    end

    // Registered display outputs aligned with the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_pins_o   <= 7'h00;
            seg_select_o <= 1'b0;
            frame_o      <= 1'b0;
        end else begin
            seg_pins_o <= w_pins_next;
            frame_o    <= w_enter_show0;
            if (w_enter_show0) begin
                seg_select_o <= 1'b0;
            end else if (w_enter_show1) begin
                seg_select_o <= 1'b1;
            end else begin
                seg_select_o <= seg_select_o;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: directed scenarios with fixed expectations
// plus a randomized run against a phase/duration reference model.
module tb_seg7_scan_ctrl;

    localparam int PW = 2;
    localparam int DC = 2;
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_pins_o;
    logic       seg_select_o;
    logic       frame_o;

    seg7_scan_ctrl_if bus_if ();

    seg7_scan_ctrl #(.PRESCALE_W(PW), .DEAD_CYCLES(DC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .seg_pins_o   (seg_pins_o),
        .seg_select_o (seg_select_o),
        .frame_o      (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: live registers, frame snapshot, phase + elapsed time
    logic [7:0] m_live [4];
    logic [7:0] s_d0, s_d1, s_ctrl, s_per;
    int         m_phase;    // -1 idle, 0 SHOW0, 1 GAP0, 2 SHOW1, 3 GAP1
    int         m_elapsed;
    logic [6:0] m_pins;
    logic       m_sel, m_frame, m_rdv;
    logic [7:0] m_rdd;

    task automatic model_step();
        int         prev;
        int         dur;
        logic [7:0] dig;
        logic [6:0] val;
        if (!rst_n) begin
            m_live[0] = 8'h00; m_live[1] = 8'h00; m_live[2] = 8'h01; m_live[3] = 8'h0F;
            s_d0 = 8'h00; s_d1 = 8'h00; s_ctrl = 8'h01; s_per = 8'h0F;
            m_phase = -1; m_elapsed = 0;
            m_pins = 7'h00; m_sel = 1'b0; m_frame = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
            return;
        end
        prev = m_phase;
        if (m_live[2][0] == 1'b0) begin
            m_phase = -1; m_elapsed = 0;
        end else if (m_phase < 0) begin
            m_phase = 0; m_elapsed = 0;
        end else begin
            dur = (m_phase % 2 == 0) ? (int'(s_per) + 1) * (1 << PW) : DC;
            if (m_elapsed + 1 >= dur) begin
                m_phase = (m_phase + 1) % 4; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        m_frame = (m_phase == 0) && (prev != 0);
        if (m_frame) begin
            s_d0 = m_live[0]; s_d1 = m_live[1]; s_ctrl = m_live[2]; s_per = m_live[3];
        end
        if (m_phase == 0 || m_phase == 2) begin
            dig = (m_phase == 0) ? s_d0 : s_d1;
            val = s_ctrl[1] ? dig[6:0] : HEX[dig[3:0]];
            m_pins = val ^ {7{s_ctrl[2]}};
            if (prev != m_phase) m_sel = (m_phase == 2);
        end else begin
            m_pins = m_live[2][2] ? 7'h7F : 7'h00;
        end
        m_rdv = bus_if.rd_req;
        m_rdd = bus_if.rd_req ? m_live[bus_if.rd_addr] : 8'h00;
        if (bus_if.wr_valid)
            m_live[bus_if.wr_addr] = (bus_if.wr_addr == 2'd2) ? (bus_if.wr_data & 8'h07) : bus_if.wr_data;
    endtask

    // One clock: model follows the edge, DUT outputs are settled 1 ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus_if.wr_valid = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d;
        tick();
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic wait_frame(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (frame_o === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++;
        if ({seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid, bus_if.rd_data} !== {7'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state: got pins=%h sel=%b frame=%b rdv=%b rdd=%h, want all zero",
                     seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid, bus_if.rd_data);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({seg_pins_o, seg_select_o, frame_o} !== {7'h3F, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_release: got pins=%h sel=%b frame=%b, want 3f/0/1", seg_pins_o, seg_select_o, frame_o);
        end
        bus_if.rd_req = 1'b1; bus_if.rd_addr = 2'd3;
        tick();
        bus_if.rd_addr = 2'd2;
        n_vec++;
        if ({bus_if.rd_valid, bus_if.rd_data} !== {1'b1, 8'h0F}) begin
            n_err++;
            $display("FAIL reset_period_read: got v=%b d=%h, want 1/0f", bus_if.rd_valid, bus_if.rd_data);
        end
        tick();
        bus_if.rd_req = 1'b0;
        n_vec++;
        if ({bus_if.rd_valid, bus_if.rd_data} !== {1'b1, 8'h01}) begin
            n_err++;
            $display("FAIL reset_ctrl_read: got v=%b d=%h, want 1/01", bus_if.rd_valid, bus_if.rd_data);
        end
    endtask

    task automatic test_frame();
        bit ok;
        logic [6:0] ep;
        logic es;
        wr(2'd3, 8'h01); wr(2'd0, 8'h03); wr(2'd1, 8'h0A);
        wait_frame(400, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL frame_timeout: got no frame_o, want one within 400 cycles"); end
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            if (k < 8)       begin ep = 7'h4F; es = 1'b0; end
            else if (k < 10) begin ep = 7'h00; es = 1'b0; end
            else if (k < 18) begin ep = 7'h77; es = 1'b1; end
            else             begin ep = 7'h00; es = 1'b1; end
            n_vec++;
            if (k == 20) begin
                if (frame_o !== 1'b1) begin
                    n_err++; $display("FAIL frame_period: got frame=%b at cycle 20, want 1", frame_o);
                end
            end else if ({seg_pins_o, seg_select_o, frame_o} !== {ep, es, (k == 0)}) begin
                n_err++;
                $display("FAIL frame_seq[%0d]: got pins=%h sel=%b frame=%b, want %h/%b/%b",
                         k, seg_pins_o, seg_select_o, frame_o, ep, es, (k == 0));
            end
        end
    endtask

    task automatic test_shadow();
        bit ok;
        tick(); tick();
        wr(2'd1, 8'h05);
        for (int i = 0; i < 7; i++) tick();
        n_vec++;
        if ({seg_pins_o, seg_select_o} !== {7'h77, 1'b1}) begin
            n_err++; $display("FAIL shadow_hold: got pins=%h sel=%b, want 77/1", seg_pins_o, seg_select_o);
        end
        wait_frame(100, ok);
        for (int i = 0; i < 10; i++) tick();
        n_vec++;
        if ({ok, seg_pins_o, seg_select_o} !== {1'b1, 7'h6D, 1'b1}) begin
            n_err++; $display("FAIL shadow_next: got ok=%b pins=%h sel=%b, want 1/6d/1", ok, seg_pins_o, seg_select_o);
        end
    endtask

    task automatic test_raw_inv();
        bit ok;
        wr(2'd2, 8'h07); wr(2'd0, 8'h81);
        wait_frame(100, ok);
        n_vec++;
        if ({ok, seg_pins_o, seg_select_o} !== {1'b1, 7'h7E, 1'b0}) begin
            n_err++; $display("FAIL raw_inv_show0: got ok=%b pins=%h sel=%b, want 1/7e/0", ok, seg_pins_o, seg_select_o);
        end
        for (int i = 0; i < 8; i++) tick();
        for (int k = 8; k < 10; k++) begin
            n_vec++;
            if (seg_pins_o !== 7'h7F) begin
                n_err++; $display("FAIL raw_inv_gap[%0d]: got pins=%h, want 7f", k, seg_pins_o);
            end
            tick();
        end
        n_vec++;
        if ({seg_pins_o, seg_select_o} !== {7'h7A, 1'b1}) begin
            n_err++; $display("FAIL raw_inv_show1: got pins=%h sel=%b, want 7a/1", seg_pins_o, seg_select_o);
        end
    endtask

    task automatic test_disable();
        wr(2'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({seg_pins_o, seg_select_o, frame_o} !== {7'h00, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL disable_idle[%0d]: got pins=%h sel=%b frame=%b, want 00/1/0",
                                  i, seg_pins_o, seg_select_o, frame_o);
            end
        end
        wr(2'd2, 8'h01);
        tick();
        n_vec++;
        if ({seg_pins_o, seg_select_o, frame_o} !== {7'h06, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL enable_show0: got pins=%h sel=%b frame=%b, want 06/0/1",
                              seg_pins_o, seg_select_o, frame_o);
        end
    endtask

    task automatic test_rw_collision();
        bus_if.rd_req = 1'b1; bus_if.rd_addr = 2'd2;
        bus_if.wr_valid = 1'b1; bus_if.wr_addr = 2'd2; bus_if.wr_data = 8'h03;
        tick();
        bus_if.rd_req = 1'b0; bus_if.wr_valid = 1'b0;
        n_vec++;
        if ({bus_if.rd_valid, bus_if.rd_data} !== {1'b1, 8'h01}) begin
            n_err++; $display("FAIL collide_read: got v=%b d=%h, want 1/01", bus_if.rd_valid, bus_if.rd_data);
        end
        tick();
        n_vec++;
        if (bus_if.rd_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_valid_pulse: got v=%b, want 0", bus_if.rd_valid);
        end
        bus_if.rd_req = 1'b1;
        tick();
        bus_if.rd_req = 1'b0;
        n_vec++;
        if ({bus_if.rd_valid, bus_if.rd_data} !== {1'b1, 8'h03}) begin
            n_err++; $display("FAIL after_write_read: got v=%b d=%h, want 1/03", bus_if.rd_valid, bus_if.rd_data);
        end
    endtask

    task automatic test_period();
        bit ok;
        int n;
        logic [7:0] pv [2];
        pv[0] = 8'd0; pv[1] = 8'd255;
        wr(2'd2, 8'h01);
        for (int j = 0; j < 2; j++) begin
            wait_frame(3000, ok);
            wr(2'd3, pv[j]);
            wait_frame(3000, ok);
            n = 0;
            while (seg_select_o !== 1'b1 && n < 3000) begin tick(); n++; end
            n_vec++;
            if (!ok || n != (int'(pv[j]) + 1) * 4 + DC) begin
                n_err++; $display("FAIL period_%0d: got ok=%b show0+gap0=%0d cycles, want %0d",
                                  pv[j], ok, n, (int'(pv[j]) + 1) * 4 + DC);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wr(2'd3, 8'h01);
        wait_frame(3000, ok);
        wait_frame(100, ok);
        for (int i = 0; i < 18; i++) tick();
        rst_n = 1'b0; bus_if.rd_req = 1'b1;
        tick();
        rst_n = 1'b1; bus_if.rd_req = 1'b0;
        n_vec++;
        if ({ok, seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid, bus_if.rd_data} !== {1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL reset_mid: got ok=%b pins=%h sel=%b frame=%b rdv=%b rdd=%h, want 1 and zeros",
                              ok, seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid, bus_if.rd_data);
        end
        tick();
        n_vec++;
        if ({seg_pins_o, seg_select_o, frame_o} !== {7'h3F, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_mid_restart: got pins=%h sel=%b frame=%b, want 3f/0/1",
                              seg_pins_o, seg_select_o, frame_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            bus_if.wr_valid = ($urandom_range(0, 5) == 0);
            bus_if.wr_addr  = 2'($urandom_range(0, 3));
            bus_if.wr_data  = 8'($urandom);
            if (bus_if.wr_addr == 2'd3) bus_if.wr_data = 8'($urandom_range(0, 2));
            if (bus_if.wr_addr == 2'd2 && $urandom_range(0, 7) != 0) bus_if.wr_data[0] = 1'b1;
            bus_if.rd_req   = ($urandom_range(0, 2) == 0);
            bus_if.rd_addr  = 2'($urandom_range(0, 3));
            tick();
            n_vec++;
            if ({seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid} !== {m_pins, m_sel, m_frame, m_rdv} ||
                (m_rdv && bus_if.rd_data !== m_rdd)) begin
                n_err++;
                $display("FAIL random[%0d]: got pins=%h sel=%b frame=%b rdv=%b rdd=%h, want %h/%b/%b/%b/%h",
                         i, seg_pins_o, seg_select_o, frame_o, bus_if.rd_valid, bus_if.rd_data,
                         m_pins, m_sel, m_frame, m_rdv, m_rdd);
            end
        end
        rst_n = 1'b1; bus_if.wr_valid = 1'b0; bus_if.rd_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.wr_valid = 1'b0; bus_if.wr_addr = 2'd0; bus_if.wr_data = 8'h00;
        bus_if.rd_req = 1'b0; bus_if.rd_addr = 2'd0;
        test_reset();
        test_frame();
        test_shadow();
        test_raw_inv();
        test_disable();
        test_rw_collision();
        test_period();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8: prescaler width; one scan tick every 2^PRESCALE_W clk cycles.
REQ-002 SHALL have parameter DEAD_CYCLES, default 4: blanking gap length in clk cycles, legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wr_valid  input  1  one-cycle register write strobe from the I2C target.
REQ-006 wr_addr  input  2  write register address.
REQ-007 wr_data  input  8  write data.
REQ-008 rd_req  input  1  one-cycle register read request.
REQ-009 rd_addr  input  2  read register address.
REQ-010 rd_data  output  8  read data, valid while rd_valid=1.
REQ-011 rd_valid  output  1  one-cycle pulse, exactly 1 cycle after rd_req.
REQ-012 seg_pins_o  output  7  segments a..g on bits 0..6.
REQ-013 seg_select_o  output  1  0 = digit 0 driven, 1 = digit 1 driven.
REQ-014 frame_o  output  1  one-cycle pulse on each SHOW0 entry.

Function
REQ-015 Register map: 0 DIGIT0, 1 DIGIT1 (8 bits each), 2 CTRL (bit0 EN, bit1 RAW, bit2 INV; bits 7:3 read 0), 3 PERIOD (8 bits).
REQ-016 Writes update live registers on the cycle after wr_valid; reads return live registers.
REQ-017 Simultaneous rd_req and wr_valid to the same address: rd_data returns the pre-write value.
REQ-018 FSM states: IDLE, SHOW0, GAP0, SHOW1, GAP1; order SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0.
REQ-019 Each SHOW phase lasts exactly (PERIOD+1)*2^PRESCALE_W cycles; each GAP lasts exactly DEAD_CYCLES cycles.
REQ-020 On SHOW0 entry, shadow copies of DIGIT0, DIGIT1, CTRL and PERIOD are loaded from the live registers; the display uses only the shadows.
REQ-021 A write in the same cycle as the shadow load is not captured; it takes effect at the next frame.
REQ-022 Segment value: RAW=0 -> hex decode of digit[3:0]; RAW=1 -> digit[6:0] direct; bit 7 is ignored.
REQ-023 Hex decode (a=bit0): 0->0x3F, 1->0x06, 2->0x5B, 3->0x4F, 4->0x66, 5->0x6D, 6->0x7D, 7->0x07, 8->0x7F, 9->0x6F, A->0x77, b->0x7C, C->0x39, d->0x5E, E->0x79, F->0x71.
REQ-024 During GAP and IDLE, segments are blank: 0x00, or 0x7F when live CTRL.INV=1.
REQ-025 In SHOW phases, seg_pins_o is the segment value XOR {7{shadow INV}}.
REQ-026 seg_select_o changes only on SHOW entry: 0 in SHOW0, 1 in SHOW1; it holds its value through the following GAP and through IDLE.
REQ-027 All display outputs are registered; the SHOW state and its pins appear in the same cycle.
REQ-028 Live EN=0 forces IDLE on the next cycle from any state; the prescaler and phase counters are cleared.
REQ-029 In IDLE with live EN=1, the FSM enters SHOW0 on the next cycle.
REQ-030 frame_o pulses in the SHOW0 entry cycle only, including entry from IDLE.
REQ-031 PERIOD=0 is legal: the SHOW phase is 2^PRESCALE_W cycles.
REQ-032 Counters wrap without overflow for PERIOD=255.

Reset
REQ-033 While rst_n=0 at a clk edge: DIGIT0=DIGIT1=0x00, CTRL=0x01, PERIOD=0x0F, and all shadows are set equal to these values.
REQ-034 Reset state: FSM=IDLE, counters=0, seg_pins_o=0x00, seg_select_o=0, rd_data=0x00, rd_valid=0, frame_o=0.
REQ-035 Reset asserted mid-frame or mid-read discards the in-flight rd_valid and frame_o.
REQ-036 The first cycle after reset release enters SHOW0, since reset EN=1.

Structure
REQ-037 Package seg7_pkg holds: address constants, CTRL bit indices, register reset values, and the FSM state enumeration.
REQ-038 Hex decoding is a combinational sub-module, seg7_hex_decode (4-bit in, 7-bit out), instantiated once and fed by a mux on the current digit.

Verification (PRESCALE_W=2, DEAD_CYCLES=2)
REQ-039 Post-reset, write PERIOD=1, DIGIT0=0x03, DIGIT1=0x0A; from the next frame: 8 cycles of 0x4F/sel0, then 2 of 0x00, then 8 of 0x77/sel1, then 2 of 0x00; frame_o period is 20 cycles.
REQ-040 Write DIGIT1=0x05 mid-SHOW0: the current frame still shows 0x77; the next frame shows 0x6D.
REQ-041 Write CTRL=0x07 (RAW, INV) and DIGIT0=0x81: the next SHOW0 shows 0x7E; GAP cycles show 0x7F.
REQ-042 Write CTRL=0x00 during SHOW1: IDLE one cycle later, with pins blank and sel held at 1; rewrite CTRL=0x01: SHOW0 entry with a frame_o pulse.
REQ-043 rd_req addr 2 issued in the same cycle as a wr_valid addr 2 of 0x03: rd_valid one cycle later with rd_data=0x01; a subsequent read returns 0x03.
REQ-044 Assert rst_n=0 for 1 cycle mid-GAP1: all outputs take their reset values, and SHOW0 follows on the first cycle after release.
